pipe_tx_skp_inserter: RTL and testbench

Transmit-path clock-compensation stage inside `phyb2b_top`, between the MAC-side TX symbol stream and the PHY PIPE TX data lane. It forwards 8b/10b-domain symbols (data + K flag) unchanged. After every `SKP_INTERVAL` transmitted symbols it schedules a SKP ordered set (COM followed by `SKP_LEN` SKP symbols). The ordered set is inserted only at packet boundaries, and the upstream is stalled while it is sent.

---
 rtl/pipe_tx_skp_inserter.sv | 221 ++++++++++++++++++++++
 tb/tb_pipe_tx_skp_inserter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_tx_skp_inserter.sv
// -----------------------------------------------------------------------------
// pipe_tx_skp_inserter
//
// Transmit-path clock-compensation stage. Forwards 8b/10b-domain symbols
// (data + K flag) from the MAC to the PIPE TX lane through a single output
// register. Every SKP_INTERVAL output symbols (and on each skp_req pulse) it
// schedules a SKP ordered set (COM followed by SKP_LEN SKP symbols), which is
// emitted only between packets while the upstream is held off.
//
// Ports
//   clk          PIPE PCLK, only clock
//   rst_n        asynchronous active-low reset
//   enable       0: pure pass-through, interval counter held at 0
//   skp_req      one-cycle pulse, adds one pending ordered set
//   in_data      symbol from MAC            in_datak   K flag of in_data
//   in_sof       first symbol of a packet   in_eof     last symbol of a packet
//   in_valid     upstream symbol valid      in_ready   symbol accepted
//   out_data     symbol to PHY              out_datak  K flag of out_data
//   out_valid    output register valid      out_ready  PHY accepts symbol
//   skp_pending  outstanding ordered sets (saturates at 3)
//   skp_sent     wrapping count of completed ordered sets
//   skp_overflow sticky: a schedule was lost because pending was full
// -----------------------------------------------------------------------------
module pipe_tx_skp_inserter #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned SKP_LEN      = 3,
  parameter logic [7:0]  COM_SYM      = 8'hBC,
  parameter logic [7:0]  SKP_SYM      = 8'h1C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        skp_req,
  input  logic [7:0]  in_data,
  input  logic        in_datak,
  input  logic        in_sof,
  input  logic        in_eof,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_datak,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  skp_pending,
  output logic [15:0] skp_sent,
  output logic        skp_overflow
);

  localparam int CNT_W = $clog2(SKP_INTERVAL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SKP_INTERVAL - 1);
  localparam logic [2:0]       SKP_LAST = 3'(SKP_LEN);

  typedef enum logic [1:0] {
    ST_PASS = 2'd0,
    ST_COM  = 2'd1,
    ST_SKP  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             mid;
  logic [CNT_W-1:0] ivl_cnt;
  logic [2:0]       skp_cnt;
  logic [2:0]       skp_cnt_nxt;

  logic             slot_free;
  logic             insert;
  logic             in_acc;
  logic             out_hs;
  logic             sched;
  logic             ld;
  logic [7:0]       ld_data;
  logic             ld_k;
  logic             com_ld;
  logic             set_done;
  logic [2:0]       pend_upd;

  // Saturating pending update: returns {lost, new_count}. A decrement only
  // happens when a COM is loaded, which requires a non-zero count, so the
  // sum never underflows. The net change is applied before saturating.
  function automatic logic [2:0] sat_pending(input logic [1:0] cur,
                                             input logic       inc_a,
                                             input logic       inc_b,
                                             input logic       dec);
    logic [2:0] sum;
    sum = {1'b0, cur} + {2'b00, inc_a} + {2'b00, inc_b} - {2'b00, dec};
    if (sum > 3'd3) begin
      sat_pending = {1'b1, 2'd3};
    end else begin
      sat_pending = {1'b0, sum[1:0]};
    end
  endfunction

  assign slot_free = !out_valid || out_ready;
  assign out_hs    = out_valid && out_ready;

  // An ordered set may start only outside a packet: either nothing is
  // offered, or the offered symbol opens a new packet.
  assign insert = enable && (skp_pending != 2'd0) && !mid && (!in_valid || in_sof);

  // Gated by rst_n so the upstream sees not-ready while reset is held.
  assign in_ready = rst_n && (state == ST_PASS) && slot_free && !insert;
  assign in_acc   = in_valid && in_ready;

  assign sched    = enable && out_hs && (ivl_cnt == CNT_LAST);
  assign pend_upd = sat_pending(skp_pending, sched, skp_req, com_ld);

  // Next state and output-register load selection
  always_comb begin
    state_nxt   = state;
    skp_cnt_nxt = skp_cnt;
    ld          = 1'b0;
    ld_data     = in_data;
    ld_k        = in_datak;
    com_ld      = 1'b0;
    set_done    = 1'b0;
    case (state)
      ST_PASS: begin
        if (slot_free && insert) begin
          ld        = 1'b1;
          ld_data   = COM_SYM;
          ld_k      = 1'b1;
          com_ld    = 1'b1;
          state_nxt = ST_COM;
        end else if (in_acc) begin
          ld = 1'b1;
        end
      end
      ST_COM: begin
        if (slot_free) begin
          ld          = 1'b1;
          ld_data     = SKP_SYM;
          ld_k        = 1'b1;
          skp_cnt_nxt = 3'd1;
          if (SKP_LEN == 1) begin
            set_done  = 1'b1;
            state_nxt = ST_PASS;
          end else begin
            state_nxt = ST_SKP;
          end
        end
      end
      ST_SKP: begin
        if (slot_free) begin
          ld          = 1'b1;
          ld_data     = SKP_SYM;
          ld_k        = 1'b1;
          skp_cnt_nxt = skp_cnt + 3'd1;
          if ((skp_cnt + 3'd1) == SKP_LAST) begin
            set_done  = 1'b1;
            state_nxt = ST_PASS;
          end
        end
      end
      default: begin
        state_nxt = ST_PASS;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_PASS;
      skp_cnt <= 3'd0;
    end else begin
      state   <= state_nxt;
      skp_cnt <= skp_cnt_nxt;
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_datak <= 1'b0;
    end else if (ld) begin
      out_valid <= 1'b1;
      out_data  <= ld_data;
      out_datak <= ld_k;
    end else if (slot_free) begin
      out_valid <= 1'b0;
    end
  end

  // Packet tracking, interval counting and ordered-set bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mid          <= 1'b0;
      ivl_cnt      <= '0;
      skp_pending  <= 2'd0;
      skp_sent     <= 16'd0;
      skp_overflow <= 1'b0;
    end else begin
      if (in_acc) begin
        if (in_eof) begin
          mid <= 1'b0;
        end else if (in_sof) begin
          mid <= 1'b1;
        end
      end

      if (!enable) begin
        ivl_cnt <= '0;
      end else if (out_hs) begin
        ivl_cnt <= (ivl_cnt == CNT_LAST) ? '0 : ivl_cnt + 1'b1;
      end

      skp_pending <= pend_upd[1:0];
      if (pend_upd[2]) begin
        skp_overflow <= 1'b1;
      end

      if (set_done) begin
        skp_sent <= skp_sent + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_tx_skp_inserter.sv
// -----------------------------------------------------------------------------
// tb_pipe_tx_skp_inserter
//
// Directed bench for pipe_tx_skp_inserter (SKP_INTERVAL=16, SKP_LEN=3).
// Inputs are driven 1 time unit after the rising edge, outputs sampled 2 units
// after it. Every output handshake is logged with the skp_pending value seen in
// that cycle and compared against a hand-built expected symbol stream.
// -----------------------------------------------------------------------------
module tb_pipe_tx_skp_inserter;

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        skp_req = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_datak = 1'b0;
  logic        in_sof = 1'b0;
  logic        in_eof = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_datak;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  skp_pending;
  logic [15:0] skp_sent;
  logic        skp_overflow;

  always #5 clk = ~clk;

  pipe_tx_skp_inserter #(
    .SKP_INTERVAL(16),
    .SKP_LEN     (3),
    .COM_SYM     (8'hBC),
    .SKP_SYM     (8'h1C)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .skp_req     (skp_req),
    .in_data     (in_data),
    .in_datak    (in_datak),
    .in_sof      (in_sof),
    .in_eof      (in_eof),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_datak   (out_datak),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .skp_pending (skp_pending),
    .skp_sent    (skp_sent),
    .skp_overflow(skp_overflow)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       k;
    logic       sof;
    logic       eof;
  } sym_t;

  sym_t       src[$];
  logic [8:0] oq[$];
  logic [8:0] exp_q[$];
  logic [1:0] pq[$];
  int         acc_at[$];

  int         n_chk = 0;
  int         n_pass = 0;
  bit         toggle_rdy = 1'b0;
  int         hold_err = 0;
  int         stall_err = 0;
  bit         was_stalled = 1'b0;
  logic [8:0] held = 9'h0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  function automatic sym_t mk(input int i, input bit sof, input bit eof);
    sym_t s;
    s.d   = 8'(i * 37 + 5);
    s.k   = ((i % 7) == 3);
    s.sof = sof;
    s.eof = eof;
    return s;
  endfunction

  function automatic logic [8:0] enc(input int i);
    sym_t s;
    s = mk(i, 1'b0, 1'b0);
    return {s.k, s.d};
  endfunction

  task automatic expect_set();
    exp_q.push_back({1'b1, COM});
    repeat (3) exp_q.push_back({1'b1, SKP});
  endtask

  task automatic clear_logs();
    oq.delete();
    exp_q.delete();
    pq.delete();
    acc_at.delete();
    hold_err  = 0;
    stall_err = 0;
  endtask

  // One clock: sample at posedge+2, advance to posedge+1.
  task automatic step(output bit acc);
    #1;
    if (was_stalled && out_valid && ({out_datak, out_data} !== held)) hold_err++;
    was_stalled = out_valid && !out_ready;
    held        = {out_datak, out_data};
    if (was_stalled && in_ready) stall_err++;
    if (out_valid && out_ready) begin
      oq.push_back({out_datak, out_data});
      pq.push_back(skp_pending);
    end
    acc = in_valid && in_ready;
    if (acc) acc_at.push_back(oq.size());
    @(posedge clk);
    #1;
    if (toggle_rdy) out_ready = ~out_ready;
  endtask

  task automatic run(input int drain);
    bit acc;
    int guard;
    guard = 0;
    while (src.size() != 0 && guard < 500) begin
      in_valid = 1'b1;
      in_data  = src[0].d;
      in_datak = src[0].k;
      in_sof   = src[0].sof;
      in_eof   = src[0].eof;
      step(acc);
      if (acc) void'(src.pop_front());
      guard++;
    end
    if (src.size() != 0) begin
      check("run_timeout_left", src.size(), 0);
      src.delete();
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
    repeat (drain) step(acc);
  endtask

  task automatic cmp_stream(input string tag);
    int nbad;
    nbad = 0;
    check({tag, "_len"}, oq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < oq.size(); i++) begin
      if (oq[i] !== exp_q[i]) begin
        if (nbad == 0) $display("%s: first diff at %0d got 0x%0h exp 0x%0h", tag, i, oq[i], exp_q[i]);
        nbad++;
      end
    end
    check({tag, "_diffs"}, nbad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;

    // Reset state
    #2 rst_n = 1'b0;
    #10;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_datak", out_datak, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_pending", skp_pending, 0);
    check("rst_sent", skp_sent, 0);
    check("rst_overflow", skp_overflow, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Pass-through with enable=0: 40 symbols, 1-cycle latency, nothing inserted
    clear_logs();
    enable   = 1'b0;
    in_valid = 1'b1;
    in_data  = mk(0, 1, 1).d;
    in_datak = mk(0, 1, 1).k;
    in_sof   = 1'b1;
    in_eof   = 1'b1;
    step(acc);
    check("pt_accept", acc, 1);
    check("pt_lat_valid", out_valid, 1);
    check("pt_lat_sym", {out_datak, out_data}, enc(0));
    exp_q.push_back(enc(0));
    for (int j = 1; j < 40; j++) begin
      src.push_back(mk(j, 1, 1));
      exp_q.push_back(enc(j));
    end
    run(3);
    cmp_stream("pt_stream");
    check("pt_sent", skp_sent, 0);
    check("pt_pending", skp_pending, 0);

    // Interval insertion at idle: single-symbol packets
    clear_logs();
    enable = 1'b1;
    for (int j = 0; j < 22; j++) src.push_back(mk(100 + j, 1, 1));
    for (int j = 0; j <= 16; j++) exp_q.push_back(enc(100 + j));
    expect_set();
    for (int j = 17; j < 22; j++) exp_q.push_back(enc(100 + j));
    run(6);
    cmp_stream("ivl_stream");
    check("ivl_sent", skp_sent, 1);

    // Boundary deferral: 8-symbol packet straddles the interval expiry
    clear_logs();
    enable = 1'b0;
    step(acc);
    enable = 1'b1;
    for (int j = 0; j < 12; j++) src.push_back(mk(200 + j, 1, 1));
    for (int j = 0; j < 8; j++) src.push_back(mk(220 + j, j == 0, j == 7));
    for (int j = 0; j < 3; j++) src.push_back(mk(230 + j, 1, 1));
    for (int j = 0; j < 12; j++) exp_q.push_back(enc(200 + j));
    for (int j = 0; j < 8; j++) exp_q.push_back(enc(220 + j));
    expect_set();
    for (int j = 0; j < 3; j++) exp_q.push_back(enc(230 + j));
    run(6);
    cmp_stream("defer_stream");
    check("defer_pend_p3", pq[15], 0);
    check("defer_pend_p4", pq[16], 1);
    check("defer_pend_p7", pq[19], 1);
    check("defer_pend_com", pq[20], 0);
    check("defer_sent", skp_sent, 2);

    // Backpressure during an ordered set
    clear_logs();
    enable = 1'b0;
    step(acc);
    enable  = 1'b1;
    skp_req = 1'b1;
    step(acc);
    skp_req = 1'b0;
    check("bp_pending", skp_pending, 1);
    out_ready  = 1'b0;
    toggle_rdy = 1'b1;
    src.push_back(mk(240, 1, 1));
    src.push_back(mk(241, 1, 1));
    expect_set();
    exp_q.push_back(enc(240));
    exp_q.push_back(enc(241));
    run(10);
    toggle_rdy = 1'b0;
    out_ready  = 1'b1;
    step(acc);
    cmp_stream("bp_stream");
    check("bp_in_accept_pos", acc_at[0], 4);
    check("bp_hold_err", hold_err, 0);
    check("bp_stall_ready", stall_err, 0);
    check("bp_sent", skp_sent, 3);

    // Saturation: four requests inside a long packet
    clear_logs();
    enable = 1'b0;
    step(acc);
    enable = 1'b1;
    src.push_back(mk(250, 1, 0));
    run(1);
    for (int i = 0; i < 4; i++) begin
      skp_req = 1'b1;
      step(acc);
      skp_req = 1'b0;
      step(acc);
      check($sformatf("sat_pending_%0d", i), skp_pending, (i < 3) ? i + 1 : 3);
      check($sformatf("sat_ovf_%0d", i), skp_overflow, (i == 3) ? 1 : 0);
    end
    src.push_back(mk(251, 0, 0));
    src.push_back(mk(252, 0, 1));
    for (int j = 250; j < 253; j++) exp_q.push_back(enc(j));
    expect_set();
    expect_set();
    expect_set();
    run(20);
    cmp_stream("sat_stream");
    check("sat_sent", skp_sent, 6);
    check("sat_pending_end", skp_pending, 0);
    check("sat_ovf_sticky", skp_overflow, 1);

    // Reset in the middle of an ordered set (interval counter left at 15)
    clear_logs();
    skp_req = 1'b1;
    step(acc);
    skp_req = 1'b0;
    step(acc);
    check("rmid_com_loaded", {out_datak, out_data}, {1'b1, COM});
    rst_n = 1'b0;
    #1;
    check("rmid_out_valid", out_valid, 0);
    check("rmid_out_data", out_data, 0);
    check("rmid_in_ready", in_ready, 0);
    check("rmid_pending", skp_pending, 0);
    check("rmid_sent", skp_sent, 0);
    check("rmid_overflow", skp_overflow, 0);
    rst_n = 1'b1;
    repeat (4) step(acc);
    check("rmid_no_stray", oq.size(), 0);
    check("rmid_idle_valid", out_valid, 0);
    for (int j = 0; j < 16; j++) begin
      src.push_back(mk(260 + j, 1, 1));
      exp_q.push_back(enc(260 + j));
    end
    expect_set();
    run(8);
    cmp_stream("rmid_stream");
    check("rmid_sent_after", skp_sent, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
